// File: rtl/ecc_rmw_writer.sv
// ECC write front end: encodes 64-bit writes as extended Hamming (72,64) words and
// performs read-modify-write for partial byte enables. Optional macro: ECC_INJECT_EN.
module ecc_rmw_writer #(
    parameter int ADDR_W     = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_data,
    input  logic [7:0]        req_be,
`ifdef ECC_INJECT_EN
    input  logic [63:0]       inject_sel,
`endif
    output logic              W_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [79:0]       W_DATA,
    output logic [7:0]        WBYTE_EN,
    output logic              R_EN,
    output logic [ADDR_W-1:0] R_ADDR,
    input  logic [79:0]       R_DATA,
    output logic              corr_pulse,
    output logic              uncorr_pulse,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, MERGE, WRITE} state_t;

    typedef struct packed {
        logic        dbl;
        logic        sgl;
        logic [63:0] data;
    } dec_t;

    state_t            state, state_nxt;
    logic [1:0]        wait_cnt;
    logic [71:0]       rd_word;
    logic [ADDR_W-1:0] lat_addr;
    logic [63:0]       lat_data;
    logic [7:0]        lat_be;
    logic [63:0]       merged;
    logic [63:0]       enc_in;
    logic [79:0]       enc_word;
    logic [79:0]       inj_mask;
    dec_t              dec;
    logic              accept, be_full, be_none, wait_last;
    logic              unused_rdata;

    // Codeword positions 1..71; data fills non-power-of-two positions in order.
    function automatic logic [79:0] encode(input logic [63:0] d);
        logic [71:0] cw;
        logic [79:0] w;
        logic        p;
        int          j;
        cw = '0;
        j  = 0;
        for (int i = 3; i < 72; i++)
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[j];
                j++;
            end
        for (int k = 0; k < 7; k++) begin
            p = 1'b0;
            for (int i = 1; i < 72; i++)
                if (i[k]) p ^= cw[i];
            cw[1 << k] = p;
        end
        cw[0] = ^cw[71:1];
        w = '0;
        w[63:0] = d;
        w[64]   = cw[0];
        for (int k = 0; k < 7; k++) w[65 + k] = cw[1 << k];
        return w;
    endfunction

    // Syndrome is the XOR of the indices of all set positions; position 0 is p0.
    function automatic dec_t decode(input logic [71:0] w);
        logic [71:0] cw;
        logic [6:0]  syn;
        logic        par;
        dec_t        r;
        int          j;
        cw    = '0;
        cw[0] = w[64];
        for (int k = 0; k < 7; k++) cw[1 << k] = w[65 + k];
        j = 0;
        for (int i = 3; i < 72; i++)
            if ((i & (i - 1)) != 0) begin
                cw[i] = w[j];
                j++;
            end
        syn = '0;
        for (int i = 1; i < 72; i++)
            if (cw[i]) syn ^= 7'(i);
        par = ^cw;
        if (par && syn < 7'd72) cw[syn] = ~cw[syn];
        r.sgl = par;
        r.dbl = ~par & (syn != 7'd0);
        r.data = '0;
        j = 0;
        for (int i = 3; i < 72; i++)
            if ((i & (i - 1)) != 0) begin
                r.data[j] = cw[i];
                j++;
            end
        return r;
    endfunction

    assign accept    = req_valid & req_ready;
    assign be_full   = (req_be == 8'hFF);
    assign be_none   = (req_be == 8'h00);
    assign wait_last = (wait_cnt == 2'(RD_LATENCY - 1));
    assign req_ready = (state == IDLE) & ~RST;
    assign WBYTE_EN  = 8'hFF;
    assign unused_rdata = &{1'b0, R_DATA[79:72]};

    always_comb begin
        dec    = decode(rd_word);
        merged = '0;
        for (int b = 0; b < 8; b++)
            merged[8*b +: 8] = lat_be[b] ? lat_data[8*b +: 8] : dec.data[8*b +: 8];
    end

`ifdef ECC_INJECT_EN
    logic [79:0] inj_live, inj_q;
    assign inj_live = (inject_sel < 64'd80) ? (80'd1 << inject_sel[6:0]) : '0;
    // Full writes encode straight from the request; RMW uses the mask captured at accept.
    assign inj_mask = (state == IDLE) ? inj_live : inj_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         inj_q <= '0;
        else if (accept) inj_q <= inj_live;
    end
`else
    assign inj_mask = '0;
`endif

    // One shared encoder: request data on the direct path, merged data in MERGE.
    assign enc_in   = (state == MERGE) ? merged : req_data;
    assign enc_word = encode(enc_in) ^ inj_mask;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept && be_full)       state_nxt = WRITE;
                      else if (accept && !be_none) state_nxt = RD_ISSUE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  if (wait_last) state_nxt = MERGE;
            MERGE:    state_nxt = dec.dbl ? IDLE : WRITE;
            WRITE:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            W_EN         <= 1'b0;
            W_ADDR       <= '0;
            W_DATA       <= '0;
            R_EN         <= 1'b0;
            R_ADDR       <= '0;
            corr_pulse   <= 1'b0;
            uncorr_pulse <= 1'b0;
            err_addr     <= '0;
            wait_cnt     <= '0;
            rd_word      <= '0;
            lat_addr     <= '0;
            lat_data     <= '0;
            lat_be       <= '0;
        end else begin
            W_EN         <= 1'b0;
            R_EN         <= 1'b0;
            corr_pulse   <= 1'b0;
            uncorr_pulse <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    lat_addr <= req_addr;
                    lat_data <= req_data;
                    lat_be   <= req_be;
                    if (be_full) begin
                        W_EN   <= 1'b1;
                        W_ADDR <= req_addr;
                        W_DATA <= enc_word;
                    end else if (!be_none) begin
                        R_EN   <= 1'b1;
                        R_ADDR <= req_addr;
                    end
                end
                RD_ISSUE: wait_cnt <= '0;
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_last) rd_word <= R_DATA[71:0];
                end
                MERGE: begin
                    if (dec.dbl) begin
                        uncorr_pulse <= 1'b1;
                        err_addr     <= lat_addr;
                    end else begin
                        W_EN   <= 1'b1;
                        W_ADDR <= lat_addr;
                        W_DATA <= enc_word;
                        if (dec.sgl) begin
                            corr_pulse <= 1'b1;
                            err_addr   <= lat_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_rmw_writer.sv
// Directed bench for ecc_rmw_writer: scoreboard of expected RAM writes plus pulse/timing checks.
module tb_ecc_rmw_writer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [13:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic [7:0]  req_be = '0;
`ifdef ECC_INJECT_EN
    logic [63:0] inject_sel = 64'd100;
`endif
    logic        W_EN, R_EN, corr_pulse, uncorr_pulse;
    logic [13:0] W_ADDR, R_ADDR, err_addr;
    logic [79:0] W_DATA;
    logic [7:0]  WBYTE_EN;
    logic [79:0] R_DATA = '0;

    ecc_rmw_writer #(.ADDR_W(14), .RD_LATENCY(1)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
`ifdef ECC_INJECT_EN
        .inject_sel(inject_sel),
`endif
        .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .WBYTE_EN(WBYTE_EN),
        .R_EN(R_EN), .R_ADDR(R_ADDR), .R_DATA(R_DATA),
        .corr_pulse(corr_pulse), .uncorr_pulse(uncorr_pulse), .err_addr(err_addr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [13:0] a;
        logic [79:0] w;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0, passed = 0, fails = 0;
    int          cyc = 0;
    int          wen_cnt = 0, ren_cnt = 0, corr_cnt = 0, uncorr_cnt = 0;
    int          wen_cyc = -1, ren_cyc = -1, corr_cyc = -1, uncorr_cyc = -1;
    logic [79:0] last_w = '0;
    logic [13:0] exp_raddr = '0;
    logic [79:0] ram_word = '0, flip = '0;
    int          pos[64];
    logic [63:0] pmask[7];

    // RAM read port with one-cycle latency and an error-injection mask.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (R_EN) R_DATA <= ram_word ^ flip;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] tb_par(input logic [63:0] d);
        logic [6:0] p;
        for (int k = 0; k < 7; k++) p[k] = ^(d & pmask[k]);
        return p;
    endfunction

    function automatic logic [79:0] tb_enc(input logic [63:0] d);
        logic [6:0] p;
        p = tb_par(d);
        return {8'h00, p, (^d) ^ (^p), d};
    endfunction

    function automatic logic [6:0] tb_syn(input logic [79:0] w);
        return tb_par(w[63:0]) ^ w[71:65];
    endfunction

    always @(negedge CLK) begin
        if (W_EN) begin
            wen_cnt++;
            wen_cyc = cyc;
            last_w  = W_DATA;
            if (sb.size() == 0) check("w_en_unexpected_sb_size", 80'(sb.size()), 80'd1);
            else begin
                e = sb.pop_front();
                check("w_addr", 80'(W_ADDR), 80'(e.a));
                check("w_data", W_DATA, e.w);
            end
        end
        if (R_EN) begin
            ren_cnt++;
            ren_cyc = cyc;
            check("r_addr", 80'(R_ADDR), 80'(exp_raddr));
        end
        if (corr_pulse)   begin corr_cnt++;   corr_cyc = cyc;   end
        if (uncorr_pulse) begin uncorr_cnt++; uncorr_cyc = cyc; end
    end

    task automatic send(input logic [13:0] a, input logic [63:0] d, input logic [7:0] be,
                        output int acc);
        int n;
        n = 0;
        @(posedge CLK); #1;
        while (!req_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!req_ready) check("ready_timeout", 80'(req_ready), 80'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_be    = be;
        @(posedge CLK); #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    initial begin
        int acc, w0, r0, c0, u0, j;
        j = 0;
        for (int i = 1; i < 72; i++)
            if ((i & (i - 1)) != 0) begin
                pos[j] = i;
                j++;
            end
        for (int k = 0; k < 7; k++) begin
            pmask[k] = '0;
            for (int b = 0; b < 64; b++) pmask[k][b] = pos[b][k];
        end

        // Reset state
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_ready", 80'(req_ready), 80'd1);
        check("rst_w_en", 80'(W_EN), 80'd0);
        check("rst_r_en", 80'(R_EN), 80'd0);
        check("rst_w_data", W_DATA, 80'd0);
        check("rst_w_addr", 80'(W_ADDR), 80'd0);
        check("rst_r_addr", 80'(R_ADDR), 80'd0);
        check("rst_err_addr", 80'(err_addr), 80'd0);
        check("rst_pulses", 80'({corr_pulse, uncorr_pulse}), 80'd0);
        check("wbyte_en", 80'(WBYTE_EN), 80'hFF);

        // Full write
        w0 = wen_cnt;
        sb.push_back('{14'd1, tb_enc(64'd11)});
        send(14'd1, 64'd11, 8'hFF, acc);
        @(negedge CLK);
        check("full_ready_busy", 80'(req_ready), 80'd0);
        @(negedge CLK);
        check("full_ready_back", 80'(req_ready), 80'd1);
        settle(2);
        check("full_wen_count", 80'(wen_cnt - w0), 80'd1);
        check("full_wen_cycle", 80'(wen_cyc), 80'(acc));
        check("full_data_low", 80'(last_w[63:0]), 80'd11);
        check("full_top_zero", 80'(last_w[79:72]), 80'd0);
        check("full_syndrome", 80'({tb_syn(last_w), ^last_w[71:0]}), 80'd0);

        // Partial, clean read
        ram_word = tb_enc(64'h1111_2222_3333_4444);
        flip = '0;
        exp_raddr = 14'd5;
        c0 = corr_cnt; u0 = uncorr_cnt;
        sb.push_back('{14'd5, tb_enc(64'h1111_2222_3333_44FF)});
        send(14'd5, 64'hFF, 8'h01, acc);
        settle(6);
        check("clean_ren_cycle", 80'(ren_cyc), 80'(acc));
        check("clean_wen_cycle", 80'(wen_cyc), 80'(acc + 3));
        check("clean_no_pulses", 80'({corr_cnt - c0, uncorr_cnt - u0}), 80'd0);

        // Partial, single data-bit error
        flip = 80'h20;
        exp_raddr = 14'd9;
        c0 = corr_cnt;
        sb.push_back('{14'd9, tb_enc(64'hAAAA_BBBB_3333_4444)});
        send(14'd9, 64'hAAAA_BBBB_0000_0000, 8'hF0, acc);
        settle(6);
        check("sbe_corr_count", 80'(corr_cnt - c0), 80'd1);
        check("sbe_corr_cycle", 80'(corr_cyc), 80'(acc + 3));
        check("sbe_err_addr", 80'(err_addr), 80'd9);

        // Partial, single error on check bit p(2)
        flip = 80'd1 << 66;
        exp_raddr = 14'd10;
        c0 = corr_cnt;
        sb.push_back('{14'd10, tb_enc(64'h1111_2222_3333_5A44)});
        send(14'd10, 64'h5A00, 8'h02, acc);
        settle(6);
        check("pbe_corr_count", 80'(corr_cnt - c0), 80'd1);
        check("pbe_err_addr", 80'(err_addr), 80'd10);

        // Partial, double error: no write
        flip = (80'd1 << 3) | (80'd1 << 40);
        exp_raddr = 14'd12;
        w0 = wen_cnt; u0 = uncorr_cnt;
        send(14'd12, 64'h0123_4567_89AB_CDEF, 8'h0F, acc);
        repeat (4) @(negedge CLK);
        check("dbe_uncorr_pulse", 80'(uncorr_pulse), 80'd1);
        check("dbe_ready", 80'(req_ready), 80'd1);
        settle(3);
        check("dbe_uncorr_count", 80'(uncorr_cnt - u0), 80'd1);
        check("dbe_err_addr", 80'(err_addr), 80'd12);
        check("dbe_no_wen", 80'(wen_cnt - w0), 80'd0);

        // Zero byte enables: nothing happens
        flip = '0;
        w0 = wen_cnt; r0 = ren_cnt;
        send(14'd20, 64'hFFFF, 8'h00, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("be0_ready", 80'(req_ready), 80'd1);
        end
        settle(2);
        check("be0_no_access", 80'({wen_cnt - w0, ren_cnt - r0}), 80'd0);

        // Reset during RD_WAIT
        exp_raddr = 14'd30;
        w0 = wen_cnt;
        send(14'd30, 64'h7777, 8'h03, acc);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_ready", 80'(req_ready), 80'd1);
        check("mid_rst_strobes", 80'({W_EN, R_EN, corr_pulse, uncorr_pulse}), 80'd0);
        check("mid_rst_w_data", W_DATA, 80'd0);
        check("mid_rst_addrs", 80'({W_ADDR, R_ADDR, err_addr}), 80'd0);
        settle(6);
        check("mid_rst_no_wen", 80'(wen_cnt - w0), 80'd0);
        w0 = wen_cnt;
        sb.push_back('{14'd33, tb_enc(64'hDEAD_BEEF)});
        send(14'd33, 64'hDEAD_BEEF, 8'hFF, acc);
        settle(3);
        check("post_rst_wen_count", 80'(wen_cnt - w0), 80'd1);
        check("post_rst_wen_cycle", 80'(wen_cyc), 80'(acc));

`ifdef ECC_INJECT_EN
        // Injected single error on data bit 40
        inject_sel = 64'd40;
        sb.push_back('{14'd2, tb_enc(64'd0) ^ (80'd1 << 40)});
        send(14'd2, 64'd0, 8'hFF, acc);
        inject_sel = 64'd100;
        settle(3);
        check("inj_bit40", 80'(last_w[40]), 80'd1);
        check("inj_syndrome", 80'(tb_syn(last_w)), 80'(pos[40]));
        check("inj_overall", 80'(^last_w[71:0]), 80'd1);
`endif

        check("scoreboard_empty", 80'(sb.size()), 80'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ecc_rmw_writer.md
Name: ecc_rmw_writer

Overview:
- Write-side front end for the 80-bit ECC-protected RAM (16K words; 64 data bits plus SECDED check bits).
- Takes 64-bit, byte-enabled write requests and encodes them as extended Hamming (72,64) words.
- Full-word writes go straight to the RAM write port.
- Partial writes use read-modify-write: read the word, correct it, merge the new bytes, re-encode, write back.
- Counterpart to the read-side decoder that produces error_flag, error_address and corrected data.

Parameters:
- ADDR_W, 14, RAM address width.
- RD_LATENCY, 1, cycles from R_EN high to R_DATA valid (1..4).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  write request valid.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  target address.
- req_data  in  64  write data.
- req_be  in  8  byte enables; bit i covers data[8i+7:8i].
- W_EN  out  1  RAM write strobe.
- W_ADDR  out  ADDR_W  RAM write address.
- W_DATA  out  80  encoded word.
- WBYTE_EN  out  8  RAM byte enables; constant 8'hFF.
- R_EN  out  1  RAM read strobe.
- R_ADDR  out  ADDR_W  RAM read address.
- R_DATA  in  80  RAM read data.
- corr_pulse  out  1  one-cycle pulse: single-bit error corrected during RMW.
- uncorr_pulse  out  1  one-cycle pulse: double-bit error found, write dropped.
- err_addr  out  ADDR_W  address of the last corrected or uncorrectable word.

Behaviour:
- Encoding, codeword positions 1..71:
  - Parity bit p(2^k) sits at position 2^k, k=0..6.
  - Data bits data[0..63] fill the non-power-of-two positions in ascending order.
  - p(2^k) = XOR of all positions whose index has bit k set.
  - Overall parity p0 = XOR of positions 1..71.
- Stored word layout: W_DATA[63:0] = data, W_DATA[64] = p0, W_DATA[64+1+k] = p(2^k), W_DATA[79:72] = 0.
- Decode on read:
  - 7-bit syndrome S = recomputed parity XOR stored parity; P = overall parity mismatch.
  - S=0, P=0: clean.
  - P=1: single error. Flip position S (S=0 means p0 itself) and raise corr_pulse.
  - S≠0, P=0: double error. Raise uncorr_pulse.
  - R_DATA[79:72] are ignored.
- Reset: state IDLE; req_ready=1 once RST is low. W_EN, R_EN, corr_pulse, uncorr_pulse = 0; W_ADDR, R_ADDR, W_DATA, err_addr = 0.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, MERGE, WRITE.
- req_ready=1 only in IDLE; one request outstanding at a time. Accept = req_valid & req_ready on a rising edge of CLK.
- Accept with req_be=8'hFF: go to WRITE. Next cycle W_EN=1 for exactly one cycle, W_DATA = encoded req_data. Return to IDLE; req_ready high on the following cycle.
- Accept with req_be=0: no RAM access; stay in IDLE. Ready stays high.
- Accept with partial be:
  - RD_ISSUE: R_EN=1 for one cycle with R_ADDR = req_addr.
  - RD_WAIT: wait RD_LATENCY cycles; capture R_DATA on the last one.
  - MERGE: decode/correct; byte i = req_data byte if be[i], else corrected old byte; re-encode.
  - WRITE: W_EN pulse.
  - Total with RD_LATENCY=1: R_EN in cycle 1, capture in cycle 2, MERGE in cycle 3, W_EN in cycle 4, ready in cycle 5.
- Double error in MERGE: raise uncorr_pulse, load err_addr, no W_EN, return to IDLE. The RAM word is left untouched.
- Single error: raise corr_pulse, load err_addr, and write the corrected, merged word.
- corr_pulse and uncorr_pulse are registered and aligned with the MERGE-exit edge. err_addr holds until the next error event.
- Outside their pulses, W_EN and R_EN are 0. W_ADDR, R_ADDR and W_DATA hold their last value.
- RST asserted mid-operation: immediate return to IDLE. A pending write is discarded, and no W_EN is issued after RST deasserts.

Optional Feature:
- Macro ECC_INJECT_EN.
- When defined, add input port inject_sel[63:0], sampled at request accept:
  - Values 0..79 flip W_DATA[inject_sel] on that request's write.
  - Values ≥80 inject nothing.
  - This mirrors the read-side selectt test hook.
- When undefined, no port exists and words are always written clean.

Test Plan:
- Full write: addr=1, data=64'd11, be=FF → single W_EN pulse at cycle+1, W_ADDR=1, W_DATA[63:0]=11, W_DATA[79:72]=0. Decoding W_DATA gives S=0, P=0.
- Partial write, clean read:
  - RAM word = encode(64'h1111_2222_3333_4444); write be=8'h01, data=64'hFF.
  - Expect R_EN, then W_EN 3 cycles later with data 64'h1111_2222_3333_44FF correctly encoded.
  - corr_pulse and uncorr_pulse stay 0.
- Partial write, R_DATA bit 5 flipped → corr_pulse one cycle, err_addr=req_addr; written data uses the corrected old bytes.
- Partial write, R_DATA bits 3 and 40 flipped → uncorr_pulse, err_addr set, no W_EN; req_ready high again next cycle.
- req_be=0 → no R_EN and no W_EN; req_ready never drops.
- RST pulsed during RD_WAIT → no W_EN afterwards; all outputs return to reset values; the next full write completes normally.
- With ECC_INJECT_EN defined: inject_sel=40, full write of 64'd0 → W_DATA[40]=1. Decode flags a single error at the data-bit-40 position.
